// File: rtl/operand_b_stage.sv
// operand_b_stage: selects the B operand (register, constant, extended
// immediate or shifted extended immediate) and holds results in a 2-entry
// in-order buffer with valid/ready handshakes on both sides.
`timescale 1ns/1ps

module operand_b_stage #(
  parameter int DATA_W    = 32,
  parameter int IMM_W     = 16,  // must not exceed DATA_W
  parameter int SHIFT     = 2,
  parameter int CONST_VAL = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        selector,
  input  logic [DATA_W-1:0] data_0,
  input  logic [IMM_W-1:0]  imm,
  input  logic              ext_unsigned,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        sel_out,
  output logic [7:0]        op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_e;

  localparam logic [DATA_W-1:0] CONST_W = DATA_W'(CONST_VAL);

  // Sign- or zero-extend the immediate to the datapath width.
  function automatic logic signed [DATA_W-1:0] extend_imm(
    input logic [IMM_W-1:0] v,
    input logic             zext
  );
    logic signed [DATA_W-1:0] r;
    if (zext) r = $signed(DATA_W'(v));
    else      r = DATA_W'($signed(v));
    return r;
  endfunction

  // Operand mux; the shifted form drops bits pushed above DATA_W-1.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] d0,
    input logic [IMM_W-1:0]  v,
    input logic              zext
  );
    logic signed [DATA_W-1:0] ext;
    logic signed [DATA_W-1:0] shifted;
    logic [DATA_W-1:0]        r;
    ext     = extend_imm(v, zext);
    shifted = ext << SHIFT;
    unique case (sel)
      2'b00:   r = d0;
      2'b01:   r = CONST_W;
      2'b10:   r = ext;
      default: r = shifted;
    endcase
    return r;
  endfunction

  state_e            state_q, state_d;
  logic              in_ready_q, out_valid_q;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [1:0]        head_sel_q, head_sel_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [1:0]        tail_sel_q, tail_sel_d;
  logic [7:0]        op_count_q, op_count_d;

  logic              accept;
  logic              pop;
  logic [DATA_W-1:0] result;

  // Handshake decode and result formation from this cycle's inputs only.
  always_comb begin
    accept = in_valid && in_ready_q;
    pop    = out_valid_q && out_ready;
    result = select_operand(selector, data_0, imm, ext_unsigned);
  end

  // Next-state and buffer update; flush forces EMPTY and freezes the entries.
  always_comb begin
    state_d     = state_q;
    head_data_d = head_data_q;
    head_sel_d  = head_sel_q;
    tail_data_d = tail_data_q;
    tail_sel_d  = tail_sel_q;
    op_count_d  = op_count_q + 8'(pop);

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          head_data_d = result;
          head_sel_d  = selector;
        end
      end
      ONE: begin
        if (accept && pop) begin
          // Old head leaves while the new result takes its place.
          head_data_d = result;
          head_sel_d  = selector;
        end else if (accept) begin
          state_d     = FULL;
          tail_data_d = result;
          tail_sel_d  = selector;
        end else if (pop) begin
          // Head values are kept but carry no meaning once EMPTY.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = ONE;
          head_data_d = tail_data_q;
          head_sel_d  = tail_sel_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (flush) begin
      state_d     = EMPTY;
      head_data_d = head_data_q;
      head_sel_d  = head_sel_q;
      tail_data_d = tail_data_q;
      tail_sel_d  = tail_sel_q;
    end
  end

  // State, registered handshake outputs, buffer entries and pop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_data_q <= '0;
      head_sel_q  <= 2'b00;
      tail_data_q <= '0;
      tail_sel_q  <= 2'b00;
      op_count_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      head_data_q <= head_data_d;
      head_sel_q  <= head_sel_d;
      tail_data_q <= tail_data_d;
      tail_sel_q  <= tail_sel_d;
      op_count_q  <= op_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = head_data_q;
  assign sel_out   = head_sel_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_operand_b_stage.sv
// Bench for operand_b_stage: directed scenarios plus randomized traffic,
// checked against a queue-based reference of the buffer.
`timescale 1ns/1ps

module tb_operand_b_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  selector = 2'b00;
  logic [31:0] data_0 = 32'd0;
  logic [15:0] imm = 16'd0;
  logic        ext_unsigned = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] data_out;
  logic [1:0]  sel_out;
  logic [7:0]  op_count;

  operand_b_stage #(.DATA_W(32), .IMM_W(16), .SHIFT(2), .CONST_VAL(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .selector(selector), .data_0(data_0), .imm(imm),
    .ext_unsigned(ext_unsigned), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .sel_out(sel_out),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  int   mpops = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] ref_result(input logic [1:0] s, input logic [31:0] d0,
                                             input logic [15:0] im, input logic zx);
    longint ext;
    longint prod;
    if (zx) ext = longint'(im);
    else    ext = longint'($signed(im));
    prod = ext * 4;
    case (s)
      2'd0:    return d0;
      2'd1:    return 32'd4;
      2'd2:    return ext[31:0];
      default: return prod[31:0];
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance model at the rising edge.
  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d0,
                      input logic [15:0] im, input logic zx, input logic fl, input logic rdy);
    logic m_acc, m_pop;
    in_valid = v; selector = s; data_0 = d0; imm = im; ext_unsigned = zx;
    flush = fl; out_ready = rdy;
    @(negedge clk);
    check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    check_val("in_ready", 32'(in_ready), 32'(mq.size() < 2));
    check_val("op_count", 32'(op_count), 32'(mpops % 256));
    if (mq.size() != 0) begin
      check_val("data_out", data_out, mq[0].data);
      check_val("sel_out", 32'(sel_out), 32'(mq[0].sel));
    end
    m_acc = v && (mq.size() < 2);
    m_pop = rdy && (mq.size() != 0);
    @(posedge clk);
    if (m_pop) mpops++;
    if (fl) mq.delete();
    else begin
      if (m_pop) void'(mq.pop_front());
      if (m_acc) mq.push_back('{sel: s, data: ref_result(s, d0, im, zx)});
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 2'b00, 32'd0, 16'd0, 1'b0, 1'b0, rdy);
  endtask

  task automatic apply_reset_mid_cycle(input string tag);
    in_valid = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    mq.delete();
    mpops = 0;
    check_val({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_val({tag, "_data_out"}, data_out, 32'd0);
    check_val({tag, "_sel_out"}, 32'(sel_out), 32'd0);
    check_val({tag, "_op_count"}, 32'(op_count), 32'd0);
    @(posedge clk);
    #1;
    check_val({tag, "_held_out_valid"}, 32'(out_valid), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // Power-on reset state.
    @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_data_out", data_out, 32'd0);
    check_val("rst_sel_out", 32'(sel_out), 32'd0);
    check_val("rst_op_count", 32'(op_count), 32'd0);
    reset = 1'b0;

    // Every selector, streaming with out_ready high.
    step(1'b1, 2'd0, 32'h12345678, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    check_val("selcov_0", data_out, 32'h12345678);
    step(1'b1, 2'd1, 32'h12345678, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    check_val("selcov_1", data_out, 32'h00000004);
    step(1'b1, 2'd2, 32'h12345678, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    check_val("selcov_2", data_out, 32'hFFFFFFFC);
    step(1'b1, 2'd3, 32'h12345678, 16'hFFFC, 1'b0, 1'b0, 1'b1);
    check_val("selcov_3", data_out, 32'hFFFFFFF0);

    // Zero- versus sign-extension with shift.
    step(1'b1, 2'd3, 32'd0, 16'h8001, 1'b1, 1'b0, 1'b1);
    check_val("zext_shift", data_out, 32'h00020004);
    step(1'b1, 2'd3, 32'd0, 16'h8001, 1'b0, 1'b0, 1'b1);
    check_val("sext_shift", data_out, 32'hFFFE0004);
    idle(1'b1);
    idle(1'b1);

    // Backpressure: third request waits until both entries drain.
    step(1'b1, 2'd0, 32'hA0000001, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'hA0000002, 16'd0, 1'b0, 1'b0, 1'b0);
    check_val("bp_in_ready_low", 32'(in_ready), 32'd0);
    step(1'b1, 2'd0, 32'hA0000003, 16'd0, 1'b0, 1'b0, 1'b0);
    check_val("bp_still_full", 32'(in_ready), 32'd0);
    step(1'b1, 2'd0, 32'hA0000003, 16'd0, 1'b0, 1'b0, 1'b1);
    check_val("bp_second_head", data_out, 32'hA0000002);
    step(1'b1, 2'd0, 32'hA0000003, 16'd0, 1'b0, 1'b0, 1'b1);
    check_val("bp_third_head", data_out, 32'hA0000003);

    // Accept and pop together while holding one entry.
    step(1'b1, 2'd2, 32'd0, 16'h1234, 1'b0, 1'b0, 1'b1);
    check_val("simul_out_valid", 32'(out_valid), 32'd1);
    check_val("simul_in_ready", 32'(in_ready), 32'd1);
    check_val("simul_head", data_out, 32'h00001234);
    check_val("simul_op_count", 32'(op_count), 32'd9);
    idle(1'b1);

    // Flush while full, with a request also offered.
    step(1'b1, 2'd0, 32'hB0000001, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'hB0000002, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'hB0000003, 16'd0, 1'b0, 1'b1, 1'b0);
    check_val("flush_out_valid", 32'(out_valid), 32'd0);
    check_val("flush_in_ready", 32'(in_ready), 32'd1);
    idle(1'b0);

    // Asynchronous reset while full, then accept on the first edge after release.
    step(1'b1, 2'd0, 32'hC0000001, 16'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'd0, 32'hC0000002, 16'd0, 1'b0, 1'b0, 1'b0);
    apply_reset_mid_cycle("arst");
    step(1'b1, 2'd1, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    check_val("post_rst_accept", 32'(out_valid), 32'd1);
    idle(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), $urandom, 16'($urandom),
           1'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end

    // op_count wrap: 256 pops return it to 0, one more makes it 1.
    apply_reset_mid_cycle("wrst");
    for (int i = 0; i < 257; i++) begin
      step(1'b1, 2'($urandom), $urandom, 16'($urandom), 1'($urandom), 1'b0, 1'b1);
    end
    check_val("wrap_256", 32'(op_count), 32'd0);
    step(1'b1, 2'd0, 32'h5, 16'd0, 1'b0, 1'b0, 1'b1);
    check_val("wrap_257", 32'(op_count), 32'd1);
    idle(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_b_stage.md
OPERAND_B_STAGE -- requirements
Module: operand_b_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of the register operand and of the result.
REQ-002 Parameter IMM_W, default 16, width of the immediate field; IMM_W SHALL be less than or equal to DATA_W.
REQ-003 Parameter SHIFT, default 2, left-shift amount applied for selector 11.
REQ-004 Parameter CONST_VAL, default 4, constant emitted for selector 01, truncated to DATA_W.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  upstream request carries a valid selection.
REQ-008 in_ready  output  1  stage can accept a request this cycle.
REQ-009 selector  input  2  00 data_0, 01 CONST_VAL, 10 extended imm, 11 extended imm << SHIFT.
REQ-010 data_0  input  DATA_W  register operand B.
REQ-011 imm  input  IMM_W  immediate field.
REQ-012 ext_unsigned  input  1  0 sign-extends imm, 1 zero-extends imm.
REQ-013 flush  input  1  synchronous discard of all buffered results.
REQ-014 out_valid  output  1  data_out holds a valid result.
REQ-015 out_ready  input  1  downstream consumes data_out this cycle.
REQ-016 data_out  output  DATA_W  oldest buffered result.
REQ-017 sel_out  output  2  selector value that produced data_out.
REQ-018 op_count  output  8  count of results consumed downstream.

Function
REQ-019 Extension SHALL replicate imm[IMM_W-1] into the upper bits when ext_unsigned=0 and SHALL fill them with 0 when ext_unsigned=1.
REQ-020 Selector 11 SHALL shift the extended value left by SHIFT, fill the low bits with 0, and drop bits above DATA_W-1.
REQ-021 The result and its selector SHALL be computed from the inputs sampled in the accept cycle only.
REQ-022 Accept SHALL occur when in_valid && in_ready, and pop SHALL occur when out_valid && out_ready.
REQ-023 Storage SHALL be a 2-entry in-order buffer controlled by the states EMPTY, ONE and FULL.
REQ-024 EMPTY SHALL go to ONE on accept and otherwise remain EMPTY.
REQ-025 ONE SHALL go to FULL on accept without pop, to EMPTY on pop without accept, and SHALL stay in ONE on accept with pop or on neither.
REQ-026 FULL SHALL go to ONE on pop and otherwise remain FULL.
REQ-027 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; in_ready SHALL be a function of state only, with no combinational path from out_ready.
REQ-028 out_valid SHALL be 1 in ONE and FULL, and data_out and sel_out SHALL present the head entry.
REQ-029 Latency SHALL be 1 cycle: a result accepted at edge N SHALL be visible with out_valid=1 after edge N.
REQ-030 Results SHALL leave in acceptance order, and no result SHALL be dropped or duplicated.
REQ-031 data_out and sel_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-032 When flush=1 the state SHALL go to EMPTY at the next edge, overriding any accept or pop in that cycle.
REQ-033 A pop in the flush cycle SHALL still increment op_count.
REQ-034 op_count SHALL increment by 1 on each pop and SHALL wrap from 255 to 0.
REQ-035 When the state is EMPTY, data_out and sel_out SHALL hold their last values, and those values SHALL have no meaning.

Reset
REQ-036 While reset=1, and immediately on its assertion, the state SHALL be EMPTY, out_valid 0, in_ready 1, data_out 0, sel_out 00 and op_count 0.
REQ-037 A reset applied mid-operation SHALL discard all buffered entries, and no pop SHALL occur during reset.
REQ-038 After reset deasserts, the first accept SHALL be allowed on the first rising edge.

Verification
REQ-039 Select coverage: with out_ready=1, feed one request per selector with data_0=0x12345678 and imm=0xFFFC -> the bench SHALL see 0x12345678, 0x00000004, 0xFFFFFFFC and 0xFFFFFFF0 in order, each one cycle after its accept.
REQ-040 Zero-extend: selector=11, imm=0x8001, ext_unsigned=1 -> the bench SHALL see 0x00020004; with ext_unsigned=0 it SHALL see 0xFFFE0004.
REQ-041 Backpressure: hold out_ready=0 and push 3 requests -> in_ready SHALL drop after 2 accepts; raising out_ready SHALL drain both entries in order, after which the third request is accepted.
REQ-042 Simultaneous: in ONE, accept and pop in the same cycle -> the state SHALL stay ONE, the new entry SHALL become the head, and op_count SHALL increment by 1.
REQ-043 Flush/reset: in FULL, assert flush together with in_valid -> the next cycle SHALL be EMPTY with out_valid=0; repeating in FULL with asynchronous reset instead SHALL clear all outputs at once, before the next edge.
REQ-044 Wrap: perform 256 pops -> op_count SHALL read 0, and a 257th pop SHALL make it read 1.
